// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the white-balance gain scheduler:
//   - wb_state_t      : scheduler FSM states
//   - wb_num_w()      : width of the divider numerator (sum << frac)
//   - wb_unity()      : unity gain for a given number of fractional bits
//   - DEF_GAIN_FRAC   : default fractional bits of the gain
//   - UNITY_GAIN      : unity gain at the default fraction
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int DEF_GAIN_FRAC = 8;

  // Scheduler states: one summing cycle, then one divide per channel.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SUM   = 3'd1,
    ST_DIV_R = 3'd2,
    ST_DIV_G = 3'd3,
    ST_DIV_B = 3'd4,
    ST_DONE  = 3'd5
  } wb_state_t;

  // The numerator is the 3-way sum (two extra carry bits) shifted up by the
  // gain fraction so the quotient comes out directly in gain units.
  function automatic int wb_num_w(input int sum_w, input int gain_frac);
    return sum_w + 2 + gain_frac;
  endfunction

  function automatic int unsigned wb_unity(input int gain_frac);
    return 32'd1 << gain_frac;
  endfunction

  localparam int unsigned UNITY_GAIN = 32'd1 << DEF_GAIN_FRAC;

endpackage

// File: rtl/wb_serial_div.sv
// -----------------------------------------------------------------------------
// wb_serial_div
// Restoring unsigned divider, one quotient bit per clock.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   load num/den; iteration begins on the following cycle
//   abort     in   synchronous abandon of the current division
//   num       in   NUM_W-bit dividend
//   den       in   DEN_W-bit divisor (den==0 yields a meaningless quotient;
//                  the caller handles that case)
//   done      out  high for one cycle, NUM_W cycles after start
//   quotient  out  final quotient, valid while done is high
//
// The quotient is presented combinationally from the last iteration so the
// caller can capture it in the same cycle done is high.
// -----------------------------------------------------------------------------
module wb_serial_div #(
  parameter int NUM_W = 38,
  parameter int DEN_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] q_reg;
  logic [DEN_W-1:0] rem_reg;
  logic [DEN_W-1:0] den_reg;
  logic [CNT_W-1:0] count;
  logic             active;

  logic [DEN_W:0]   rem_shift;
  logic [DEN_W:0]   trial;
  logic [DEN_W-1:0] rem_next;
  logic [NUM_W-1:0] q_next;
  logic             q_bit;

  // One restoring step: bring down the next dividend bit, try a subtract,
  // keep the difference only when it did not go negative. The dividend is
  // shifted out of q_reg from the top while quotient bits enter at the bottom.
  always_comb begin
    rem_shift = {rem_reg, q_reg[NUM_W-1]};
    trial     = rem_shift - {1'b0, den_reg};
    q_bit     = ~trial[DEN_W];
    rem_next  = q_bit ? trial[DEN_W-1:0] : rem_shift[DEN_W-1:0];
    q_next    = {q_reg[NUM_W-2:0], q_bit};
  end

  // Iteration control: count holds the number of steps still to run.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      active  <= 1'b0;
      count   <= '0;
      q_reg   <= '0;
      rem_reg <= '0;
      den_reg <= '0;
    end else if (start) begin
      active  <= 1'b1;
      count   <= CNT_W'(NUM_W);
      q_reg   <= num;
      rem_reg <= '0;
      den_reg <= den;
    end else if (active) begin
      q_reg   <= q_next;
      rem_reg <= rem_next;
      count   <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        active <= 1'b0;
      end
    end
  end

  assign done     = active && (count == CNT_W'(1));
  assign quotient = q_next;

endmodule

// File: rtl/wb_gain_sched.sv
// -----------------------------------------------------------------------------
// wb_gain_sched
// Per-frame gray-world gain scheduler. On a vsync rise the R/G/B frame sums
// are latched, then one shared serial divider computes (R+G+B)/(3*C) for each
// channel in turn. The resulting gain set is held in shadow registers and
// applied atomically at the following vsync rise.
//
// Optional feature (macro WB_SMOOTH_EN): when defined, each applied gain moves
// only part of the way toward the new value:
//   g_out + ((shadow - g_out) >>> SMOOTH_SH)
// When undefined, the shadow value is applied directly.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   synchronous active-high reset
//   vsync       in   frame sync
//   en          in   allow new computations to start
//   r_sum       in   previous-frame red sum     (SUM_W)
//   g_sum       in   previous-frame green sum   (SUM_W)
//   b_sum       in   previous-frame blue sum    (SUM_W)
//   r_gain      out  applied red gain           (GAIN_W, GAIN_FRAC frac bits)
//   g_gain      out  applied green gain
//   b_gain      out  applied blue gain
//   gain_valid  out  one-cycle pulse when a new gain set is applied
//   busy        out  computation in progress
//   overrun     out  sticky: a frame boundary arrived mid-computation
// -----------------------------------------------------------------------------
module wb_gain_sched
  import wb_pkg::*;
#(
  parameter int SUM_W     = 28,
  parameter int GAIN_W    = 10,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int SMOOTH_SH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              en,
  input  logic [SUM_W-1:0]  r_sum,
  input  logic [SUM_W-1:0]  g_sum,
  input  logic [SUM_W-1:0]  b_sum,
  output logic [GAIN_W-1:0] r_gain,
  output logic [GAIN_W-1:0] g_gain,
  output logic [GAIN_W-1:0] b_gain,
  output logic              gain_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int DEN_W = SUM_W + 2;
  localparam int NUM_W = wb_num_w(SUM_W, GAIN_FRAC);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(wb_unity(GAIN_FRAC));

  wb_state_t state, state_next;

  logic              vsync_d;
  logic              rise;
  logic              computing;

  logic [SUM_W-1:0]  r_lat, g_lat, b_lat;
  logic [NUM_W-1:0]  num_reg;
  logic [GAIN_W-1:0] sh_r, sh_g, sh_b;
  logic              pending;
  logic              div_first, div_first_next;

  logic              latch_sums;
  logic              apply_now;
  logic              div_abort;
  logic              capture_r, capture_g, capture_b;
  logic              set_pending;

  logic [DEN_W-1:0]  total;
  logic [SUM_W-1:0]  cur_sum;
  logic [DEN_W-1:0]  den;
  logic              div_done;
  logic [NUM_W-1:0]  quotient;
  logic [GAIN_W-1:0] chan_gain;

  // Partial step toward the new gain; the signed difference always fits in
  // GAIN_W+1 bits and the result always lands back inside the gain range.
  function automatic logic [GAIN_W-1:0] smooth_step(input logic [GAIN_W-1:0] cur,
                                                    input logic [GAIN_W-1:0] target);
    logic signed [GAIN_W:0] diff;
    logic signed [GAIN_W:0] step;
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    step = diff >>> SMOOTH_SH;
    return cur + step[GAIN_W-1:0];
  endfunction

  assign rise      = vsync & ~vsync_d;
  assign computing = (state == ST_SUM) || (state == ST_DIV_R) ||
                     (state == ST_DIV_G) || (state == ST_DIV_B);
  assign busy      = computing;

  // Divider operands: the numerator is built once in SUM, the denominator is
  // 3x the sum of whichever channel the FSM is currently dividing.
  always_comb begin
    total = {2'b00, r_lat} + {2'b00, g_lat} + {2'b00, b_lat};
    unique case (state)
      ST_DIV_G: cur_sum = g_lat;
      ST_DIV_B: cur_sum = b_lat;
      default:  cur_sum = r_lat;
    endcase
    den = {1'b0, cur_sum, 1'b0} + {2'b00, cur_sum};
  end

  // Channel result: an empty channel keeps unity gain, oversized quotients
  // clamp to the largest representable gain.
  always_comb begin
    if (den == '0) begin
      chan_gain = UNITY;
    end else if (|quotient[NUM_W-1:GAIN_W]) begin
      chan_gain = '1;
    end else begin
      chan_gain = quotient[GAIN_W-1:0];
    end
  end

  wb_serial_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_first),
    .abort    (div_abort),
    .num      (num_reg),
    .den      (den),
    .done     (div_done),
    .quotient (quotient)
  );

  // Next-state and control. A frame boundary during a computation overrides
  // everything: the run is dropped and restarted on the freshly latched sums.
  always_comb begin
    state_next  = state;
    latch_sums  = 1'b0;
    apply_now   = 1'b0;
    div_abort   = 1'b0;
    capture_r   = 1'b0;
    capture_g   = 1'b0;
    capture_b   = 1'b0;
    set_pending = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rise && en) begin
          state_next = ST_SUM;
          latch_sums = 1'b1;
        end
      end
      ST_SUM: begin
        state_next = ST_DIV_R;
      end
      ST_DIV_R: begin
        if (div_done) begin
          capture_r  = 1'b1;
          state_next = ST_DIV_G;
        end
      end
      ST_DIV_G: begin
        if (div_done) begin
          capture_g  = 1'b1;
          state_next = ST_DIV_B;
        end
      end
      ST_DIV_B: begin
        if (div_done) begin
          capture_b   = 1'b1;
          set_pending = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rise) begin
          apply_now  = pending;
          latch_sums = 1'b1;
          state_next = en ? ST_SUM : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (computing && rise) begin
      state_next  = ST_SUM;
      latch_sums  = 1'b1;
      div_abort   = 1'b1;
      capture_r   = 1'b0;
      capture_g   = 1'b0;
      capture_b   = 1'b0;
      set_pending = 1'b0;
    end

    // The divider is loaded in the first cycle of each DIV state.
    div_first_next = ((state_next == ST_DIV_R) || (state_next == ST_DIV_G) ||
                      (state_next == ST_DIV_B)) && (state_next != state);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_first <= 1'b0;
    end else begin
      state     <= state_next;
      div_first <= div_first_next;
    end
  end

  // Datapath registers: sum latches, numerator, shadow and applied gains.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d    <= 1'b0;
      r_lat      <= '0;
      g_lat      <= '0;
      b_lat      <= '0;
      num_reg    <= '0;
      sh_r       <= UNITY;
      sh_g       <= UNITY;
      sh_b       <= UNITY;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      gain_valid <= 1'b0;
      r_gain     <= UNITY;
      g_gain     <= UNITY;
      b_gain     <= UNITY;
    end else begin
      vsync_d    <= vsync;
      gain_valid <= apply_now;

      if (latch_sums) begin
        r_lat <= r_sum;
        g_lat <= g_sum;
        b_lat <= b_sum;
      end

      if (state == ST_SUM) begin
        num_reg <= NUM_W'(total) << GAIN_FRAC;
      end

      if (capture_r) sh_r <= chan_gain;
      if (capture_g) sh_g <= chan_gain;
      if (capture_b) sh_b <= chan_gain;

      if (set_pending) begin
        pending <= 1'b1;
      end else if (apply_now) begin
        pending <= 1'b0;
      end

      if (div_abort) begin
        overrun <= 1'b1;
      end

      if (apply_now) begin
`ifdef WB_SMOOTH_EN
        r_gain <= smooth_step(r_gain, sh_r);
        g_gain <= smooth_step(g_gain, sh_g);
        b_gain <= smooth_step(b_gain, sh_b);
`else
        r_gain <= sh_r;
        g_gain <= sh_g;
        b_gain <= sh_b;
`endif
      end
    end
  end

endmodule

// File: doc/wb_gain_sched.md
# wb_gain_sched

Per-frame gain scheduler for the white-balance path. On each frame boundary it samples the R/G/B frame sums from the statistics accumulator. It then uses one shared serial divider to compute the gray-world gains `(R+G+B)/(3·C)` for each channel C, one channel after another. The new gain set is applied atomically at the next frame boundary. It sits between the per-frame statistics accumulator and the pixel gain multipliers, and replaces per-channel reciprocal lookups with a single time-shared divider.

## Interface
- `SUM_W`, 28: width of each per-channel frame sum.
- `GAIN_W`, 10: gain output width, unsigned fixed point.
- `GAIN_FRAC`, 8: fractional bits of the gain; unity gain is `1<<GAIN_FRAC` = 256.
- `SMOOTH_SH`, 2: IIR shift, used only when `WB_SMOOTH_EN` is defined.

- `clk`, in, 1: pixel clock, the single clock of the block.
- `rst`, in, 1: synchronous, active-high reset.
- `vsync`, in, 1: frame sync from the unpacked stream.
- `en`, in, 1: when low, no new computation starts; outputs hold their values.
- `r_sum`, `g_sum`, `b_sum`, in, SUM_W each: previous-frame sums, stable during the cycle in which a vsync rise is detected.
- `r_gain`, `g_gain`, `b_gain`, out, GAIN_W each: applied gains.
- `gain_valid`, out, 1: one-cycle pulse when a new gain set is applied.
- `busy`, out, 1: high while a computation is in progress.
- `overrun`, out, 1: sticky flag; set when a frame boundary arrives before the computation finishes.

## Operation
- **Vsync rise detection:** `vsync_d` is a registered copy of `vsync`. A rise is `vsync & ~vsync_d`.
- **FSM states:** IDLE, SUM, DIV_R, DIV_G, DIV_B, DONE.
- **IDLE → SUM** on a rise with `en=1`. On that edge the three sums are latched.
- **SUM (1 cycle):**
  - `total = r+g+b`, SUM_W+2 bits.
  - Numerator `N = total << GAIN_FRAC`, NUM_W = SUM_W+2+GAIN_FRAC = 38 bits.
- **DIV_x:**
  - Denominator `D = 3·x_sum`, SUM_W+2 bits. It is loaded into the divider in 1 cycle.
  - The restoring divider then runs NUM_W iterations, 1 bit per cycle.
  - The quotient truncates toward zero.
- **Per-channel result rules:**
  - If `D==0`: shadow gain = unity.
  - Else if quotient > `2^GAIN_W-1`: shadow gain saturates to 1023.
  - Otherwise: shadow gain = quotient.
- **DIV_B done → DONE** with `pending=1`.
- **DONE, on the next rise:**
  - The shadow gains go to the outputs and `gain_valid` pulses.
  - New sums are latched.
  - The FSM goes to SUM if `en=1`, otherwise to IDLE.
- **Rise while in SUM or DIV_x (short frame):**
  - The current computation is aborted.
  - `overrun` is set.
  - Outputs are unchanged, and no shadow gains are applied from the aborted run.
  - New sums are latched and the FSM restarts at SUM.
- **`en` falling mid-computation:** the current computation completes to DONE. It is applied at the next rise, even if `en` is still low.
- **Clearing `overrun`:** only `rst` clears it.
- **Reset:**
  - Gains = 256.
  - `gain_valid`, `busy`, `overrun`, `pending` = 0.
  - FSM = IDLE.
  - Reset mid-division discards the result.

## Timing
- A rise is detected in cycle T. SUM runs in T+1, DIV_R starts in T+2.
- `busy` is high from T+1 for 1+3·(NUM_W+1) = 118 cycles. The FSM is in DONE at T+119.
- Outputs change on the edge ending the next rise-detect cycle, so they are visible in cycle T'+1. `gain_valid` is high in T'+1 only.
- Gains change only at frame boundaries. The total lag from statistics to applied gain is one frame after the sums are latched.

## Configuration
- **`WB_SMOOTH_EN` defined:** the applied gain is `g_out + ((shadow - g_out) >>> SMOOTH_SH)`.
  - Computed as signed GAIN_W+1 bits, with an arithmetic shift.
  - It is registered on the apply edge, with the same timing as the undefined case.
- **Undefined:** the shadow value is applied directly.

## Structure
- **Package `wb_pkg`:**
  - FSM state enum.
  - NUM_W derivation function.
  - Unity-gain constant.
  - Default `GAIN_FRAC`.
- **Sub-module `wb_serial_div`:**
  - Restoring divider, NUM_W-bit numerator and SUM_W+2-bit denominator.
  - `start`/`done` handshake.
  - `done` pulses NUM_W cycles after `start`.
  - Synchronous `abort` input.

## Test plan
Macro undefined unless stated.
- Reset, then idle 10 cycles → gains 256/256/256; `gain_valid`, `busy`, `overrun` = 0.
- Sums 1000/1000/1000, then a second rise 2000 cycles later → at T'+1 gains 256/256/256 and `gain_valid` = 1 for exactly 1 cycle.
- Sums 1000/2000/3000, then a second rise → gains 512/256/170; `busy` is high for exactly 118 cycles.
- Sums 0/500/500 → r_gain = 256. Sums 1/100000/100000 → r_gain = 1023 (saturated).
- Second rise 50 cycles after the first → `overrun` = 1 and stays 1, gains unchanged. The next complete frame applies results from the new sums.
- `rst` pulsed during DIV_G, then a normal frame → reset values after `rst`, then correct gains. With `WB_SMOOTH_EN` and sums 1000/2000/3000: r_gain 256 → 320 on the first apply.
